// File: rtl/safe_pulse_transfer_pkg.sv
// Shared constants and types for the safe_pulse_transfer clock-domain crossing.
// Optional feature macro: SPT_PENDING_EN (one-deep pending capture in the src domain).
package safe_pulse_transfer_pkg;

  localparam int SPT_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    SPT_IDLE         = 2'd0,
    SPT_REQ          = 2'd1,
    SPT_WAIT_ACK_LOW = 2'd2
  } spt_src_state_e;

endpackage

// File: rtl/safe_pulse_transfer_spt_sync.sv
// Multi-flop level synchronizer with synchronous active-high reset.
// Used for req into dst_clock and for ack back into src_clock.
module spt_sync
  import safe_pulse_transfer_pkg::*;
#(
  parameter int SYNC_STAGES = SPT_SYNC_STAGES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/safe_pulse_transfer.sv
// Single-cycle pulse transfer between src_clock and dst_clock over a 4-phase req/ack handshake.
// Define SPT_PENDING_EN to capture one extra pulse arriving while a handshake is in flight.
module safe_pulse_transfer
  import safe_pulse_transfer_pkg::*;
#(
  parameter int SYNC_STAGES = SPT_SYNC_STAGES_DEFAULT
) (
  input  logic src_clock,
  input  logic src_reset,
  input  logic dst_clock,
  input  logic dst_reset,
  input  logic pulse_in,
  output logic pulse_out,
  output logic src_busy
);

  spt_src_state_e r_state;
  logic           r_req;
  logic           r_req_d;
  logic           r_pulse_out;
  logic           w_ack_sync;
  logic           w_req_sync;
  logic           w_core_busy;
  logic           w_launch;

  assign w_core_busy = r_req | w_ack_sync;

`ifdef SPT_PENDING_EN
  logic r_pending;

  assign w_launch = (pulse_in | r_pending) & ~w_core_busy;
  assign src_busy = w_core_busy | r_pending;

  // A pulse coinciding with a pending launch is the third event of the window and is dropped.
  always_ff @(posedge src_clock) begin
    if (src_reset) begin
      r_pending <= 1'b0;
    end else if (w_launch) begin
      r_pending <= 1'b0;
    end else if (pulse_in & w_core_busy) begin
      r_pending <= 1'b1;
    end
  end
`else
  assign w_launch = pulse_in & ~w_core_busy;
  assign src_busy = w_core_busy;
`endif

  always_ff @(posedge src_clock) begin
    if (src_reset) begin
      r_state <= SPT_IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        SPT_IDLE: begin
          if (w_launch) begin
            r_req   <= 1'b1;
            r_state <= SPT_REQ;
          end
        end
        SPT_REQ: begin
          if (w_ack_sync) begin
            r_req   <= 1'b0;
            r_state <= SPT_WAIT_ACK_LOW;
          end
        end
        SPT_WAIT_ACK_LOW: begin
          if (!w_ack_sync) begin
            if (w_launch) begin
              r_req   <= 1'b1;
              r_state <= SPT_REQ;
            end else begin
              r_state <= SPT_IDLE;
            end
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= SPT_IDLE;
        end
      endcase
    end
  end

  spt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .i_clk (dst_clock),
    .i_rst (dst_reset),
    .i_d   (r_req),
    .o_q   (w_req_sync)
  );

  always_ff @(posedge dst_clock) begin
    if (dst_reset) begin
      r_req_d     <= 1'b0;
      r_pulse_out <= 1'b0;
    end else begin
      r_req_d     <= w_req_sync;
      r_pulse_out <= w_req_sync & ~r_req_d;
    end
  end

  assign pulse_out = r_pulse_out;

  // The acknowledge is the synchronized request itself, a flop output in the dst domain.
  spt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .i_clk (src_clock),
    .i_rst (src_reset),
    .i_d   (w_req_sync),
    .o_q   (w_ack_sync)
  );

endmodule

// File: tb/tb_safe_pulse_transfer.sv
// Scoreboard bench for safe_pulse_transfer; expected pulses are queued at stimulus time.
// Expectations follow SPT_PENDING_EN when the bench is compiled with that macro.
module tb_safe_pulse_transfer;

  logic src_clock = 1'b0;
  logic dst_clock = 1'b0;
  logic src_reset = 1'b1;
  logic dst_reset = 1'b1;
  logic pulse_in  = 1'b0;
  logic pulse_out;
  logic src_busy;

  int src_half = 2;
  int dst_half = 8;

  int vectors     = 0;
  int miscompares = 0;

  int   exp_q[$];
  int   pulse_times[$];
  int   pulse_cnt = 0;
  int   wide_cnt  = 0;
  int   dst_cyc   = 0;
  logic prev_out  = 1'b0;

  safe_pulse_transfer dut (
    .src_clock (src_clock),
    .src_reset (src_reset),
    .dst_clock (dst_clock),
    .dst_reset (dst_reset),
    .pulse_in  (pulse_in),
    .pulse_out (pulse_out),
    .src_busy  (src_busy)
  );

  always #(src_half) src_clock = ~src_clock;
  always #(dst_half) dst_clock = ~dst_clock;

  always @(posedge dst_clock) dst_cyc++;

  // Pulse monitor: every dst cycle with pulse_out high is one observed event.
  always @(negedge dst_clock) begin
    if (pulse_out === 1'b1) begin
      pulse_cnt++;
      pulse_times.push_back(dst_cyc);
      if (prev_out === 1'b1) wide_cnt++;
    end
    prev_out = pulse_out;
  end

  task automatic drive_pulse();
    @(posedge src_clock);
    #1 pulse_in = 1'b1;
    @(posedge src_clock);
    #1 pulse_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && src_busy !== 1'b0; i++) @(negedge src_clock);
    vectors++;
    if (src_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: src_busy=%b, required 0 within 400 src cycles", name, src_busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge dst_clock);
    @(negedge src_clock);
    vectors++;
    if (src_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: src_busy=%b, required 0", src_busy);
    end
    vectors++;
    if (pulse_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulse: pulse_out=%b, required 0", pulse_out);
    end
    src_reset = 1'b0;
    dst_reset = 1'b0;
    repeat (4) @(negedge dst_clock);
    vectors++;
    if (src_busy !== 1'b0 || pulse_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_release: src_busy=%b pulses=%0d, required 0 and 0", src_busy, pulse_cnt);
    end
  endtask

  task automatic test_single();
    int p0;
    p0 = pulse_cnt;
    repeat (8) @(posedge src_clock);
    exp_q.push_back(1);
    drive_pulse();
    repeat (5) @(negedge dst_clock);
    vectors++;
    if (pulse_cnt - p0 != 1) begin
      miscompares++;
      $display("FAIL single_latency: %0d pulses within 5 dst cycles, required 1", pulse_cnt - p0);
    end
    wait_idle("single");
    repeat (10) @(negedge dst_clock);
    for (int k = p0; k < pulse_cnt; k++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL single_sb: extra pulse_out at dst cycle %0d, required none", pulse_times[k]);
      end else void'(exp_q.pop_front());
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (wide_cnt != 0) begin
      miscompares++;
      $display("FAIL single_width: %0d wide pulse cycles, required 0", wide_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    exp_q.push_back(1);
`ifdef SPT_PENDING_EN
    exp_q.push_back(2);
`endif
    @(posedge src_clock);
    #1 pulse_in = 1'b1;
    @(posedge src_clock);
    #1 pulse_in = 1'b0;
    repeat (2) @(posedge src_clock);
    #1 pulse_in = 1'b1;
    @(posedge src_clock);
    #1 pulse_in = 1'b0;
    wait_idle("b2b");
    repeat (10) @(negedge dst_clock);
`ifdef SPT_PENDING_EN
    vectors++;
    if (pulse_cnt - p0 < 2 || pulse_times[p0+1] - pulse_times[p0] < 2) begin
      miscompares++;
      $display("FAIL b2b_spacing: %0d pulses, required 2 separated by >=2 dst cycles", pulse_cnt - p0);
    end
`endif
    for (int k = p0; k < pulse_cnt; k++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_sb: extra pulse_out at dst cycle %0d, required none", pulse_times[k]);
      end else void'(exp_q.pop_front());
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_held_high();
    int p0;
    p0 = pulse_cnt;
    @(posedge src_clock);
    #1 pulse_in = 1'b1;
    repeat (20) @(posedge src_clock);
    #1 pulse_in = 1'b0;
    wait_idle("held");
    repeat (10) @(negedge dst_clock);
    vectors++;
    if (pulse_cnt - p0 < 1 || pulse_cnt - p0 > 3) begin
      miscompares++;
      $display("FAIL held_count: %0d pulses, required 1 to 3", pulse_cnt - p0);
    end
    vectors++;
    if (wide_cnt != 0) begin
      miscompares++;
      $display("FAIL held_width: %0d wide pulse cycles, required 0", wide_cnt);
    end
  endtask

  task automatic test_src_reset();
    int p0;
    int p1;
    p0 = pulse_cnt;
    drive_pulse();
    @(negedge src_clock);
    vectors++;
    if (src_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL srst_busy: src_busy=%b after accept, required 1", src_busy);
    end
    @(posedge src_clock);
    #1 src_reset = 1'b1;
    repeat (2) @(posedge src_clock);
    #1 src_reset = 1'b0;
    repeat (20) @(negedge dst_clock);
    vectors++;
    if (src_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL srst_drain: src_busy=%b, required 0", src_busy);
    end
    vectors++;
    if (pulse_cnt - p0 > 1) begin
      miscompares++;
      $display("FAIL srst_dup: %0d pulses, required at most 1", pulse_cnt - p0);
    end
    p1 = pulse_cnt;
    exp_q.push_back(1);
    drive_pulse();
    wait_idle("srst_after");
    repeat (10) @(negedge dst_clock);
    for (int k = p1; k < pulse_cnt; k++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL srst_sb: extra pulse_out at dst cycle %0d, required none", pulse_times[k]);
      end else void'(exp_q.pop_front());
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL srst_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_both_resets();
    int p0;
    p0 = pulse_cnt;
    drive_pulse();
    src_reset = 1'b1;
    dst_reset = 1'b1;
    @(posedge dst_clock);
    @(negedge dst_clock);
    vectors++;
    if (pulse_out !== 1'b0) begin
      miscompares++;
      $display("FAIL both_rst_pulse: pulse_out=%b in reset, required 0", pulse_out);
    end
    @(posedge dst_clock);
    #1;
    src_reset = 1'b0;
    dst_reset = 1'b0;
    repeat (30) @(negedge dst_clock);
    vectors++;
    if (pulse_cnt - p0 != 0) begin
      miscompares++;
      $display("FAIL both_rst_spurious: %0d pulses, required 0", pulse_cnt - p0);
    end
    vectors++;
    if (src_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL both_rst_busy: src_busy=%b, required 0", src_busy);
    end
  endtask

  task automatic test_reversed_ratio();
    int p0;
    src_half = 8;
    dst_half = 2;
    repeat (3) @(posedge src_clock);
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(i);
      drive_pulse();
      repeat (18) @(posedge src_clock);
    end
    wait_idle("rev");
    repeat (20) @(negedge dst_clock);
    for (int k = p0; k < pulse_cnt; k++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rev_sb: extra pulse_out at dst cycle %0d, required none", pulse_times[k]);
      end else void'(exp_q.pop_front());
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rev_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (wide_cnt != 0) begin
      miscompares++;
      $display("FAIL rev_width: %0d wide pulse cycles, required 0", wide_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_held_high();
    test_src_reset();
    test_both_resets();
    test_reversed_ratio();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
